// File: rtl/scalar_mult_ctrl_if.sv
// Bundle between the scalar multiplier sequencer, its requester and the shared PointAdd unit.
// i_start/o_finished and o_pa_start/i_pa_finished are single-cycle pulses; there is no ready
// back-pressure, so a start is only honoured in IDLE and a finished is only honoured in a WAIT state.
interface scalar_mult_ctrl_if #(parameter int W = 256);
  logic         i_start;
  logic [W-1:0] i_k, i_x, i_y, i_z;
  logic         o_busy, o_finished, o_is_identity;
  logic [W-1:0] o_x, o_y, o_z;
  logic         o_pa_start, o_pa_doubling;
  logic [W-1:0] o_pa_x1, o_pa_y1, o_pa_z1;
  logic [W-1:0] o_pa_x2, o_pa_y2, o_pa_z2;
  logic [W-1:0] i_pa_x3, i_pa_y3, i_pa_z3;
  logic         i_pa_finished;

  modport slave (
    input  i_start, i_k, i_x, i_y, i_z,
    output o_busy, o_finished, o_is_identity, o_x, o_y, o_z,
    output o_pa_start, o_pa_doubling,
    output o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2,
    input  i_pa_x3, i_pa_y3, i_pa_z3, i_pa_finished
  );

  modport master (
    output i_start, i_k, i_x, i_y, i_z,
    input  o_busy, o_finished, o_is_identity, o_x, o_y, o_z,
    input  o_pa_start, o_pa_doubling,
    input  o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2,
    output i_pa_x3, i_pa_y3, i_pa_z3, i_pa_finished
  );
endinterface

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer: scans k MSB first and drives one shared PointAdd
// unit with doubling/addition requests, returning k*P in projective coordinates.
module scalar_mult_ctrl #(
  parameter int           W    = 256,
  parameter logic [W-1:0] ID_X = '0,
  parameter logic [W-1:0] ID_Y = {{(W-1){1'b0}}, 1'b1},
  parameter logic [W-1:0] ID_Z = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic                i_clk,
  input  logic                i_rst,
  scalar_mult_ctrl_if.slave   bus,
  output logic [3:0]          dbg_state
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [3:0] {
    IDLE, SCAN, NEXT, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  k_r, px, py, pz, qx, qy, qz;

  // Operand buses come straight from the accumulator and latched base point,
  // which only change on a PointAdd result or a new start.
  assign bus.o_pa_x1 = qx;
  assign bus.o_pa_y1 = qy;
  assign bus.o_pa_z1 = qz;
  assign bus.o_pa_x2 = px;
  assign bus.o_pa_y2 = py;
  assign bus.o_pa_z2 = pz;
  assign dbg_state   = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state             <= IDLE;
      idx               <= '0;
      k_r               <= '0;
      px                <= '0;
      py                <= '0;
      pz                <= '0;
      qx                <= '0;
      qy                <= '0;
      qz                <= '0;
      bus.o_busy        <= 1'b0;
      bus.o_finished    <= 1'b0;
      bus.o_is_identity <= 1'b0;
      bus.o_x           <= '0;
      bus.o_y           <= '0;
      bus.o_z           <= '0;
      bus.o_pa_start    <= 1'b0;
      bus.o_pa_doubling <= 1'b0;
    end else begin
      bus.o_finished <= 1'b0;
      bus.o_pa_start <= 1'b0;
      case (state)
        IDLE: begin
          // Gating on o_finished keeps the pulse cycle from re-arming the sequencer.
          if (bus.i_start && !bus.o_finished) begin
            k_r        <= bus.i_k;
            px         <= bus.i_x;
            py         <= bus.i_y;
            pz         <= bus.i_z;
            idx        <= IW'(W - 1);
            bus.o_busy <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (k_r[idx]) begin
            qx    <= px;
            qy    <= py;
            qz    <= pz;
            state <= NEXT;
          end else if (idx == '0) begin
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        NEXT: begin
          if (idx == '0) begin
            state <= DONE;
          end else begin
            idx               <= idx - 1'b1;
            bus.o_pa_start    <= 1'b1;
            bus.o_pa_doubling <= 1'b1;
            state             <= DBL_REQ;
          end
        end
        DBL_REQ: state <= DBL_WAIT;
        DBL_WAIT: begin
          if (bus.i_pa_finished) begin
            qx <= bus.i_pa_x3;
            qy <= bus.i_pa_y3;
            qz <= bus.i_pa_z3;
            if (k_r[idx]) begin
              bus.o_pa_start    <= 1'b1;
              bus.o_pa_doubling <= 1'b0;
              state             <= ADD_REQ;
            end else begin
              state <= NEXT;
            end
          end
        end
        ADD_REQ: state <= ADD_WAIT;
        ADD_WAIT: begin
          if (bus.i_pa_finished) begin
            qx    <= bus.i_pa_x3;
            qy    <= bus.i_pa_y3;
            qz    <= bus.i_pa_z3;
            state <= NEXT;
          end
        end
        DONE: begin
          if (k_r == '0) begin
            bus.o_x           <= ID_X;
            bus.o_y           <= ID_Y;
            bus.o_z           <= ID_Z;
            bus.o_is_identity <= 1'b1;
          end else begin
            bus.o_x           <= qx;
            bus.o_y           <= qy;
            bus.o_z           <= qz;
            bus.o_is_identity <= 1'b0;
          end
          bus.o_finished <= 1'b1;
          bus.o_busy     <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
